// File: rtl/npu_mult_pkg.sv
// Shared NPU multiplier types.
//   OP_W / PROD_W : operand and product widths of the shared multiplier
//   op_t / prod_t : signed operand and product types
package npu_mult_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef logic signed [OP_W-1:0]   op_t;
  typedef logic signed [PROD_W-1:0] prod_t;
endpackage

// File: rtl/mult_share_arb_if.sv
// Requester/response bus of the shared-multiplier arbiter.
//   req_valid/req_ready : per-requester operand handshake (NREQ bits each)
//   req_m/req_q         : packed signed operands, requester i at [8i+7:8i]
//   rsp_valid/rsp_ready : product handshake
//   rsp_id/rsp_prod     : requester index and signed product
//   modport slave  : the arbiter side
//   modport master : the requester/consumer side
//
// Handshake rule, both channels: a transfer happens on a rising edge where
// valid and ready are both high. A producer holding valid must keep its data
// stable until the transfer; valid must never depend on ready. ready may
// depend combinationally on valid.
interface mult_share_arb_if
  import npu_mult_pkg::*;
#(
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_m;
  logic [NREQ*OP_W-1:0] req_q;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  prod_t                rsp_prod;

  modport slave (
    input  req_valid, req_m, req_q, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod
  );

  modport master (
    output req_valid, req_m, req_q, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod
  );
endinterface

// File: rtl/booth_mult_8b.sv
// Combinational radix-4 Booth 8x8 signed multiplier.
//   m : signed multiplicand
//   q : signed multiplier
//   p : exact signed 16-bit product m*q
module booth_mult_8b
  import npu_mult_pkg::*;
(
  input  op_t   m,
  input  op_t   q,
  output prod_t p
);
  logic [PROD_W-1:0] mx;
  logic [PROD_W-1:0] pp;
  logic [PROD_W-1:0] acc;
  logic [OP_W:0]     qx;

  // Four Booth digits, each in {-2,-1,0,1,2}, from overlapping 3-bit windows
  // of {q, 0}. Summing modulo 2^16 is exact because |m*q| <= 2^14.
  always_comb begin
    mx  = {{(PROD_W-OP_W){m[OP_W-1]}}, m};
    qx  = {q, 1'b0};
    acc = '0;
    pp  = '0;
    for (int k = 0; k < OP_W / 2; k++) begin
      case (qx[2*k +: 3])
        3'b001, 3'b010: pp = mx;
        3'b011:         pp = mx << 1;
        3'b100:         pp = -(mx << 1);
        3'b101, 3'b110: pp = -mx;
        default:        pp = '0;
      endcase
      acc = acc + (pp << (2 * k));
    end
    p = prod_t'(acc);
  end
endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter that time-shares one Booth multiplier among NREQ
// requesters and registers the product into a single-entry output stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester operand handshakes and product response
//   ops_cnt  : completed response handshakes, wraps at 2^CNT_W
//   dbg_ptr  : current round-robin search start
module mult_share_arb
  import npu_mult_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_share_arb_if.slave      bus,
  output logic [CNT_W-1:0]     ops_cnt,
  output logic [ID_W-1:0]      dbg_ptr
);
  logic [ID_W-1:0] ptr;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  prod_t           rsp_prod_q;

  logic            can_load;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  op_t             m_arr [NREQ];
  op_t             q_arr [NREQ];
  op_t             m_sel;
  op_t             q_sel;
  prod_t           prod;

  // (base + off) mod NREQ for base < NREQ and off < NREQ.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[ID_W-1:0];
  endfunction

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign m_arr[i] = bus.req_m[OP_W*i +: OP_W];
    assign q_arr[i] = bus.req_q[OP_W*i +: OP_W];
  end

  assign can_load = !rsp_valid_q || bus.rsp_ready;

  // First valid requester at or after ptr. Nothing is granted while the
  // output stage is stalled or during reset, so a requester that drops
  // valid in the meantime is simply skipped.
  always_comb begin
    gnt_found     = 1'b0;
    gnt_idx       = '0;
    bus.req_ready = '0;
    if (can_load && !rst) begin
      for (int off = 0; off < NREQ; off++) begin
        if (!gnt_found && bus.req_valid[rr_idx(ptr, off)]) begin
          gnt_found = 1'b1;
          gnt_idx   = rr_idx(ptr, off);
        end
      end
    end
    if (gnt_found) bus.req_ready[gnt_idx] = 1'b1;
  end

  assign m_sel = m_arr[gnt_idx];
  assign q_sel = q_arr[gnt_idx];

  booth_mult_8b u_mult (
    .m (m_sel),
    .q (q_sel),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      ops_cnt     <= '0;
    end else begin
      if (rsp_valid_q && bus.rsp_ready) ops_cnt <= ops_cnt + 1'b1;
      if (gnt_found) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= gnt_idx;
        rsp_prod_q  <= prod;
        ptr         <= rr_idx(gnt_idx, 1);
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign dbg_ptr       = ptr;
endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;
  logic       clk;
  logic       rst;
  logic [3:0] ops_cnt;
  logic [1:0] dbg_ptr;

  mult_share_arb_if #(.NREQ(4)) bus ();

  mult_share_arb #(.NREQ(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .ops_cnt (ops_cnt),
    .dbg_ptr (dbg_ptr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [17:0] exp_q[$];      // {id, prod}
  logic [15:0] cur_prod [4];  // hand-computed product of each requester's operands
  logic        exp_rv  = 1'b0;
  logic [3:0]  exp_ops = '0;
  logic [1:0]  exp_ptr = '0;

  // Corner operand table: (-128,-128) (-128,127) (127,127) (-1,-1) (0,-77)
  logic [7:0]  cm [5] = '{8'h80, 8'h80, 8'h7F, 8'hFF, 8'h00};
  logic [7:0]  cq [5] = '{8'h80, 8'h7F, 8'h7F, 8'hFF, 8'hB3};
  // 16384, -16256, 16129, 1, 0
  logic [15:0] cp [5] = '{16'h4000, 16'hC080, 16'h3F01, 16'h0001, 16'h0000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [7:0] m, input logic [7:0] q,
                        input logic [15:0] prod);
    bus.req_m[8*i +: 8] = m;
    bus.req_q[8*i +: 8] = q;
    cur_prod[i] = prod;
  endtask

  // One clock cycle: drive inputs, check grant/status mid-cycle, push the
  // expected response for the granted requester, then advance the model.
  task automatic cyc(input logic [3:0] v, input logic rr, input logic [3:0] rdy);
    int gid;
    gid = -1;
    bus.req_valid = v;
    bus.rsp_ready = rr;
    for (int i = 0; i < 4; i++) if (rdy[i]) gid = i;
    @(negedge clk);
    check("req_ready", 32'(bus.req_ready), 32'(rdy));
    check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_rv));
    check("ops_cnt", 32'(ops_cnt), 32'(exp_ops));
    check("ptr", 32'(dbg_ptr), 32'(exp_ptr));
    if (exp_rv && !rr && exp_q.size() > 0) begin
      check("hold_id", 32'(bus.rsp_id), 32'(exp_q[0][17:16]));
      check("hold_prod", 32'($unsigned(bus.rsp_prod)), 32'(exp_q[0][15:0]));
    end
    if (!rst && gid >= 0) exp_q.push_back({2'(gid), cur_prod[gid]});
    @(posedge clk);
    if (rst) begin
      exp_rv  = 1'b0;
      exp_ops = '0;
      exp_ptr = '0;
      exp_q.delete();
    end else begin
      if (exp_rv && rr) exp_ops = exp_ops + 4'd1;
      if (gid >= 0) begin
        exp_rv  = 1'b1;
        exp_ptr = 2'(gid + 1);
      end else if (rr) begin
        exp_rv = 1'b0;
      end
    end
    #1;
  endtask

  task automatic probe_ops(input string name, input logic [3:0] val);
    @(negedge clk);
    check(name, 32'(ops_cnt), 32'(val));
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected id=%0d prod=%0h t=%0t", bus.rsp_id, bus.rsp_prod, $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(bus.rsp_id), 32'(e[17:16]));
        check("rsp_prod", 32'($unsigned(bus.rsp_prod)), 32'(e[15:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst           = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    bus.req_m     = '0;
    bus.req_q     = '0;
    set_op(0, 8'h03, 8'h04, 16'h000C);  //   3 *   4 =   12
    set_op(1, 8'hFE, 8'h07, 16'hFFF2);  //  -2 *   7 =  -14
    set_op(2, 8'h0A, 8'hF6, 16'hFF9C);  //  10 * -10 = -100
    set_op(3, 8'hF8, 8'hF8, 16'h0040);  //  -8 *  -8 =   64
    @(posedge clk);
    #1;

    // Reset held with every requester valid: no grants.
    repeat (3) cyc(4'b1111, 1'b1, 4'b0000);
    rst = 1'b0;
    cyc(4'b1111, 1'b1, 4'b0001);        // first grant to requester 0
    cyc(4'b0000, 1'b1, 4'b0000);

    // Corner products on requester 2, one per cycle.
    for (int i = 0; i < 5; i++) begin
      set_op(2, cm[i], cq[i], cp[i]);
      cyc(4'b0100, 1'b1, 4'b0100);
    end
    cyc(4'b0000, 1'b1, 4'b0000);
    set_op(2, 8'h0A, 8'hF6, 16'hFF9C);

    // Fairness from a fresh reset.
    rst = 1'b1;
    cyc(4'b1111, 1'b1, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) cyc(4'b1111, 1'b1, 4'(1 << (i % 4)));
    cyc(4'b0000, 1'b1, 4'b0000);
    probe_ops("ops_after_fair", 4'd12);

    // Backpressure: requester 1 (5 * -3 = -15) held for 5 stalled cycles.
    set_op(1, 8'h05, 8'hFD, 16'hFFF1);
    cyc(4'b0010, 1'b1, 4'b0010);
    repeat (5) cyc(4'b1111, 1'b0, 4'b0000);
    cyc(4'b1111, 1'b1, 4'b0100);        // drain and regrant in one cycle
    cyc(4'b0000, 1'b1, 4'b0000);

    // Sparse: bring ptr to 2, then only 1 and 3 valid.
    cyc(4'b0010, 1'b1, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b1000);
    cyc(4'b1010, 1'b1, 4'b0010);
    cyc(4'b1010, 1'b1, 4'b1000);
    cyc(4'b1010, 1'b1, 4'b0010);

    // Skip: requester 3 valid only while stalled, then drops.
    cyc(4'b0010, 1'b1, 4'b0010);
    repeat (2) cyc(4'b1000, 1'b0, 4'b0000);
    cyc(4'b0010, 1'b1, 4'b0010);
    cyc(4'b0000, 1'b1, 4'b0000);
    cyc(4'b0000, 1'b1, 4'b0000);

    // Counter wrap: 17 handshakes on a 4-bit counter.
    rst = 1'b1;
    cyc(4'b0000, 1'b1, 4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) cyc(4'b1111, 1'b1, 4'(1 << (i % 4)));
    cyc(4'b0000, 1'b1, 4'b0000);
    probe_ops("ops_wrap", 4'd1);

    // Reset while a response is pending.
    cyc(4'b0010, 1'b0, 4'b0010);
    rst = 1'b1;
    cyc(4'b0000, 1'b1, 4'b0000);
    rst = 1'b0;
    cyc(4'b0000, 1'b1, 4'b0000);
    probe_ops("ops_after_rst", 4'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer that time-shares one combinational radix-4 Booth 8×8 signed multiplier among `NREQ` requesters in the NPU datapath. Each requester presents an operand pair with a valid/ready handshake. The block grants at most one requester per cycle, drives the shared multiplier, and registers the 16-bit signed product into a single-entry output stage tagged with the requester id. It sits between the PE-side operand queues and the accumulate logic.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2–8.
- `ID_W`, default `$clog2(NREQ)`: requester-id width; derived, not overridden.
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NREQ: per-requester operand valid.
- `req_ready`  out  NREQ: per-requester grant; one-hot or zero.
- `req_m`  in  NREQ×8: packed signed multiplicands; requester i uses `[8i+7:8i]`.
- `req_q`  in  NREQ×8: packed signed multipliers, same packing.
- `rsp_valid`  out  1: product register holds a result.
- `rsp_ready`  in  1: downstream accepts the result.
- `rsp_id`  out  ID_W: index of the requester that produced `rsp_prod`.
- `rsp_prod`  out  16: signed product `m*q`.
- `ops_cnt`  out  CNT_W: count of completed response handshakes.

## Operation
- Output stage "can load" when `!rsp_valid || rsp_ready`.
- Grant selection:
  - When the output stage can load, `req_ready[i]` = 1 for the first i with `req_valid[i]`, searching `ptr, ptr+1, …` mod NREQ.
  - All other bits of `req_ready` are 0.
  - When the output stage cannot load, `req_ready` = 0.
- `req_ready` may depend combinationally on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- Requesters must not make `req_valid` depend on `req_ready`.
- Transfer occurs on `req_valid[i] && req_ready[i]`. The granted operands are muxed into the shared multiplier. On the same edge:
  - `rsp_prod` ← product.
  - `rsp_id` ← i.
  - `rsp_valid` ← 1.
  - `ptr` ← (i+1) mod NREQ.
- No transfer and `rsp_ready` high: `rsp_valid` ← 0. `rsp_prod` and `rsp_id` hold their values.
- While `rsp_valid && !rsp_ready`: `rsp_prod` and `rsp_id` stay stable, and no grant is issued.
- `ops_cnt` increments by 1 on each `rsp_valid && rsp_ready` and wraps from 2^CNT_W−1 to 0.
- Arithmetic: operands are two's complement. The full 16-bit product is exact; −128×−128 = +16384 needs no saturation.
- A requester whose `req_valid` drops before a grant is simply skipped. No state is kept per requester.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_prod`=0, `ops_cnt`=0, `ptr`=0.
- `req_ready` is 0 during the reset cycle.
- Reset asserted mid-operation discards any pending response. No handshake completes in that cycle.
- Latency: operand handshake at edge N, so `rsp_valid`/`rsp_prod` are visible after edge N.
- Throughput: with `rsp_ready` held high, one grant per cycle. Back-to-back: a response handshake and a new grant in the same cycle reload the register.
- With all requesters valid continuously, the grant order is 0,1,…,NREQ−1,0,… and each requester gets exactly 1/NREQ of the grants.
- `ptr` changes only on a grant. Idle cycles and stalled cycles do not rotate it.

## Structure
- Shared package `npu_mult_pkg`:
  - `OP_W`=8 and `PROD_W`=16.
  - typedef `op_t` (signed [7:0]) and `prod_t` (signed [15:0]).
- One sub-module instance: `booth_mult_8b`, the combinational shared multiplier.
- Round-robin first-match search lives in-line; a separate priority module is not warranted.
- Registers: `ptr` (ID_W bits), output stage (1 + ID_W + 16 bits), `ops_cnt`.

## Test plan
- **Reset:** hold `rst` 3 cycles with all `req_valid`=1.
  - During reset: `req_ready`=0.
  - After release: `rsp_valid`=0, `ops_cnt`=0.
  - First grant goes to requester 0.
- **Corner products, single requester 2, `rsp_ready`=1:**
  - Operand pairs (−128,−128), (−128,127), (127,127), (−1,−1), (0,−77).
  - Required `rsp_prod`: 16384, −16256, 16129, 1, 0.
  - Each response has `rsp_id`=2 and arrives one cycle after its handshake.
- **Fairness:** all 4 requesters valid for 12 cycles with `rsp_ready`=1.
  - `rsp_id` sequence is 0,1,2,3 repeated three times.
  - `ops_cnt`=12 at the end.
- **Backpressure:** `rsp_ready`=0 for 5 cycles after a grant from requester 1 with m=5, q=−3.
  - `rsp_prod`=−15 and `rsp_id`=1 hold stable throughout.
  - `req_ready`=0 throughout.
  - When `rsp_ready` goes high, the next grant lands in the same cycle as the handshake.
- **Sparse and skip:**
  - Only requesters 1 and 3 valid, `ptr`=2 → grant order 3,1,3,1.
  - Requester 3 drops `req_valid` before its grant → it is skipped; `ptr` is unchanged until the next grant.
- **Counter wrap and mid-op reset:**
  - With CNT_W=4, 17 response handshakes → `ops_cnt`=1.
  - Assert `rst` while `rsp_valid`=1 → next cycle `rsp_valid`=0 and no handshake is counted.
